// File: rtl/cordic_pair_collector_pkg.sv
// Shared types for the CORDIC pair collector: FSM state encodings, default widths, pair layout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cordic_pair_collector_pkg;

    localparam int CORDIC_DATA_WIDTH_DEF = 22;
    localparam int FLOAT_DATA_WIDTH_DEF  = 32;
    localparam int DEPTH_DEF             = 2;
    localparam int COUNT_WIDTH_DEF       = 16;

    // WAIT_FIRST is the all-zero encoding so reset lands there; IDLE is reserved and recovers to WAIT_FIRST.
    typedef enum logic [1:0] {
        WAIT_FIRST  = 2'd0,
        WAIT_SECOND = 2'd1,
        IDLE        = 2'd2
    } pair_state_e;

    // FIFO entry layout, most significant field first: {x_one, x_two, sq_one, sq_two}.
    typedef struct packed {
        logic [CORDIC_DATA_WIDTH_DEF-1:0] x_one;
        logic [CORDIC_DATA_WIDTH_DEF-1:0] x_two;
        logic [FLOAT_DATA_WIDTH_DEF-1:0]  sq_one;
        logic [FLOAT_DATA_WIDTH_DEF-1:0]  sq_two;
    } pair_t;

endpackage

// File: rtl/cordic_pair_collector_if.sv
// Beat input, launch/credit and pair output bundle of the CORDIC pair collector (PAIR_ORPHAN_CHECK_EN adds orphan_err).
// Latency: none (wiring only).
// Backpressure: out_valid/out_ready on the pair side; busy withholds launch credit on the issue side.
interface cordic_pair_collector_if
    import cordic_pair_collector_pkg::*;
#(
    parameter int CW   = CORDIC_DATA_WIDTH_DEF,
    parameter int FW   = FLOAT_DATA_WIDTH_DEF,
    parameter int CNTW = COUNT_WIDTH_DEF
);
    logic            clk_en;
    logic            launch;
    logic [CW-1:0]   in_result;
    logic [FW-1:0]   in_squared;
    logic            in_valid;
    logic            busy;
    logic [CW-1:0]   out_x_one;
    logic [CW-1:0]   out_x_two;
    logic [FW-1:0]   out_sq_one;
    logic [FW-1:0]   out_sq_two;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] pair_count;
    logic            overflow;
`ifdef PAIR_ORPHAN_CHECK_EN
    logic            orphan_err;

    modport slave (
        input  clk_en, launch, in_result, in_squared, in_valid, out_ready,
        output busy, out_x_one, out_x_two, out_sq_one, out_sq_two, out_valid,
               pair_count, overflow, orphan_err
    );
    modport master (
        output clk_en, launch, in_result, in_squared, in_valid, out_ready,
        input  busy, out_x_one, out_x_two, out_sq_one, out_sq_two, out_valid,
               pair_count, overflow, orphan_err
    );
`else
    modport slave (
        input  clk_en, launch, in_result, in_squared, in_valid, out_ready,
        output busy, out_x_one, out_x_two, out_sq_one, out_sq_two, out_valid,
               pair_count, overflow
    );
    modport master (
        output clk_en, launch, in_result, in_squared, in_valid, out_ready,
        input  busy, out_x_one, out_x_two, out_sq_one, out_sq_two, out_valid,
               pair_count, overflow
    );
`endif
endinterface

// File: rtl/cordic_pair_collector_pair_fifo.sv
// Synchronous DEPTH-entry FIFO of completed pairs, head entry always visible on rd_dat_o.
// Latency: a write is visible on rd_vld_o/rd_dat_o one cycle later.
// Backpressure: write dropped when full unless a read happens in the same cycle (wr_acc_o reports acceptance).
module cordic_pair_collector_pair_fifo #(
    parameter int  WIDTH = 108,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             wr_acc_o,
    input  logic             rd_rdy_i,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [OW-1:0]    occ_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             full, rd_en;

    assign full     = (occ_q == OW'(DEPTH));
    assign rd_vld_o = (occ_q != '0);
    assign rd_en    = rd_vld_o & rd_rdy_i;
    assign wr_acc_o = wr_vld_i & (~full | rd_en);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign occ_o    = occ_q;

    // Occupancy: a simultaneous read and write leaves it unchanged
    always_comb begin
        occ_d = occ_q;
        if (wr_acc_o && !rd_en) begin
            occ_d = occ_q + OW'(1);
        end else if (!wr_acc_o && rd_en) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_acc_o) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/cordic_pair_collector.sv
// Re-pairs CORDIC result beats, buffers pairs in a FIFO and issues launch credits (option: PAIR_ORPHAN_CHECK_EN).
// Latency: a pair is presented on out_valid one cycle after its second beat.
// Backpressure: out_ready stalls the FIFO; busy is raised once in-flight launches plus stored pairs fill DEPTH.
module cordic_pair_collector
    import cordic_pair_collector_pkg::*;
#(
    parameter int CORDIC_DATA_WIDTH = CORDIC_DATA_WIDTH_DEF,
    parameter int FLOAT_DATA_WIDTH  = FLOAT_DATA_WIDTH_DEF,
    parameter int DEPTH             = DEPTH_DEF,
    parameter int COUNT_WIDTH       = COUNT_WIDTH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    cordic_pair_collector_if.slave bus
);
    localparam int CW    = CORDIC_DATA_WIDTH;
    localparam int FW    = FLOAT_DATA_WIDTH;
    localparam int PW    = 2 * CW + 2 * FW;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = OW + 1;

    pair_state_e      state_q, state_d;
    logic [CW-1:0]    first_x_q, first_x_d;
    logic [FW-1:0]    first_sq_q, first_sq_d;
    logic [OW-1:0]    in_flight_q, in_flight_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic             pair_done, orphan, release_credit, launch_acc;
    logic             wr_acc, rd_en;
    logic [OW-1:0]    occ, occ_next;
    logic [PW-1:0]    pair_dat, head_dat;

    assign pair_dat       = {first_x_q, bus.in_result, first_sq_q, bus.in_squared};
    assign release_credit = pair_done | orphan;
    assign rd_en          = bus.out_valid & bus.out_ready;

    cordic_pair_collector_pair_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (pair_done),
        .wr_dat_i (pair_dat),
        .wr_acc_o (wr_acc),
        .rd_rdy_i (bus.out_ready),
        .rd_vld_o (bus.out_valid),
        .rd_dat_o (head_dat),
        .occ_o    (occ)
    );

    assign bus.out_x_one  = head_dat[PW-1 -: CW];
    assign bus.out_x_two  = head_dat[PW-CW-1 -: CW];
    assign bus.out_sq_one = head_dat[2*FW-1 -: FW];
    assign bus.out_sq_two = head_dat[FW-1:0];
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.pair_count = count_q;

    // Pair FSM: hold the first beat, complete on the next valid beat, drop it as an orphan on a gap
    always_comb begin
        state_d    = state_q;
        first_x_d  = first_x_q;
        first_sq_d = first_sq_q;
        pair_done  = 1'b0;
        orphan     = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (bus.in_valid) begin
                    first_x_d  = bus.in_result;
                    first_sq_d = bus.in_squared;
                    state_d    = WAIT_SECOND;
                end
            end
            WAIT_SECOND: begin
                pair_done = bus.in_valid;
                orphan    = ~bus.in_valid;
                state_d   = WAIT_FIRST;
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    // Credit accounting: busy looks ahead at next-cycle in_flight and occupancy so no extra launch slips in
    always_comb begin
        launch_acc  = bus.launch & bus.clk_en & ~busy_q;
        in_flight_d = in_flight_q;
        if (launch_acc && !release_credit) begin
            in_flight_d = in_flight_q + OW'(1);
        end else if (!launch_acc && release_credit && in_flight_q != '0) begin
            in_flight_d = in_flight_q - OW'(1);
        end
        occ_next = occ;
        if (wr_acc && !rd_en) begin
            occ_next = occ + OW'(1);
        end else if (!wr_acc && rd_en) begin
            occ_next = occ - OW'(1);
        end
        busy_d     = ({1'b0, in_flight_d} + {1'b0, occ_next}) >= SUM_W'(DEPTH);
        overflow_d = overflow_q | (pair_done & ~wr_acc);
        count_d    = count_q;
        if (wr_acc) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // State registers; reset discards any half-captured pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_FIRST;
            first_x_q   <= '0;
            first_sq_q  <= '0;
            in_flight_q <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            first_x_q   <= first_x_d;
            first_sq_q  <= first_sq_d;
            in_flight_q <= in_flight_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
        end
    end

`ifdef PAIR_ORPHAN_CHECK_EN
    logic orphan_err_q;

    // Sticky orphan flag, raised the cycle after a WAIT_SECOND cycle without a beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orphan_err_q <= 1'b0;
        end else begin
            orphan_err_q <= orphan_err_q | orphan;
        end
    end

    assign bus.orphan_err = orphan_err_q;
`endif
endmodule
